// File: rtl/seq_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with a start/done handshake,
// optional two's-complement mode and optional early termination.
module seq_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             Eq,
    output logic             L
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [1:0] D_EQ = 2'd0;
    localparam logic [1:0] D_GT = 2'd1;
    localparam logic [1:0] D_LT = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx;
    logic             last;
    logic [1:0]       dec;
    logic             g_q;
    logic             eq_q;
    logic             l_q;

    logic       bit_a;
    logic       bit_b;
    logic       sign_pos;
    logic [1:0] bit_dec;
    logic       finish;

    // The sign bit of a two's-complement operand carries negative weight,
    // so its greater/less sense is swapped.
    always_comb begin
        bit_a    = a_q[idx];
        bit_b    = b_q[idx];
        sign_pos = sgn_q && (idx == TOP_IDX);
        bit_dec  = D_EQ;
        if (bit_a && !bit_b)
            bit_dec = sign_pos ? D_LT : D_GT;
        else if (!bit_a && bit_b)
            bit_dec = sign_pos ? D_GT : D_LT;
    end

    // The decision is registered first and acted on one edge later; index 0
    // being examined is remembered in 'last' because the index never wraps.
    assign finish = last || (EARLY_EXIT && (dec != D_EQ));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset also clears the operand regs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            idx   <= TOP_IDX;
            last  <= 1'b0;
            dec   <= D_EQ;
            g_q   <= 1'b0;
            eq_q  <= 1'b1;
            l_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sgn_q <= signed_mode;
                        idx   <= TOP_IDX;
                        last  <= 1'b0;
                        dec   <= D_EQ;
                        state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (finish) begin
                        state <= S_DONE;
                        g_q   <= (dec == D_GT);
                        eq_q  <= (dec == D_EQ);
                        l_q   <= (dec == D_LT);
                    end else begin
                        if (dec == D_EQ)
                            dec <= bit_dec;
                        if (idx == '0)
                            last <= 1'b1;
                        else
                            idx <= idx - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_COMPARE);
    assign done = (state == S_DONE);
    assign G    = g_q;
    assign Eq   = eq_q;
    assign L    = l_q;

endmodule
